// File: rtl/icache_line_server_pkg.sv
// Shared definitions for the instruction cache and its SDRAM line server:
// line-server state encoding, the RISC-V NOP filler word and the default
// cache line length.
package icache_line_server_pkg;

  localparam int          DEFAULT_LINE_WORDS = 16;
  localparam logic [31:0] NOP_INSN           = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    GAP    = 2'd3
  } line_state_e;

endpackage

// File: rtl/icache_line_server_line_buffer.sv
// Line buffer for icache_line_server: LINE_WORDS x 32 register file with one
// write port (memory return side) and one combinational read port (stream
// side). Contents are intentionally not reset.
module icache_line_server_line_buffer #(
  parameter int LINE_WORDS = 16
) (
  input  logic                          clk,
  input  logic                          wr_en_i,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_idx_i,
  input  logic [31:0]                   wr_data_i,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_idx_i,
  output logic [31:0]                   rd_data_o
);

  logic [31:0] words_q [LINE_WORDS];

  // Capture each returned word at its position in the line.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      words_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = words_q[rd_idx_i];

endmodule

// File: rtl/icache_line_server.sv
// icache_line_server: fetches one aligned cache line word-by-word from the
// SDRAM controller into a line buffer, then streams it to the instruction
// cache for LINE_WORDS back-to-back cycles followed by one idle gap cycle.
// Optional feature: define ICACHE_RESP_TIMEOUT_EN to add a fetch watchdog that
// replaces a stuck line with LINE_WORDS NOP words after TIMEOUT_CYC cycles
// without a memory return.
module icache_line_server
  import icache_line_server_pkg::*;
#(
  parameter int LINE_WORDS  = DEFAULT_LINE_WORDS,
  parameter int ADDR_W      = 21,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              sdram_clk,
  input  logic              reset_n,
  input  logic              icache_ren,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic [31:0]       line_data,
  output logic              line_ack,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_busy,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int               IDX_W    = $clog2(LINE_WORDS);
  localparam int               CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LINE_WORDS);

  line_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issue_q, issue_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic              nop_fill_q, nop_fill_d;
  logic              buf_we;
  logic              timeout_hit;
  logic [31:0]       buf_rd_data;

`ifdef ICACHE_RESP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  // Watchdog register: consecutive FETCH cycles without a memory return.
  always_ff @(posedge sdram_clk or negedge reset_n) begin
    if (!reset_n) wd_q <= '0;
    else          wd_q <= wd_d;
  end

  // Count up while fetching and starved; any return or other state restarts it.
  always_comb begin
    wd_d = '0;
    if (state_q == FETCH && !mem_rvalid) wd_d = wd_q + 1'b1;
  end

  assign timeout_hit = (state_q == FETCH) && !mem_rvalid &&
                       (wd_q == WD_W'(TIMEOUT_CYC - 1));
`else
  // No watchdog: a fetch waits for its returns indefinitely. A non-positive
  // limit would be meaningless, so this term is constant zero in practice.
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  // State and counter registers; everything returns to idle on reset.
  always_ff @(posedge sdram_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      issue_q    <= '0;
      ret_q      <= '0;
      out_q      <= '0;
      nop_fill_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      issue_q    <= issue_d;
      ret_q      <= ret_d;
      out_q      <= out_d;
      nop_fill_q <= nop_fill_d;
    end
  end

  // Next-state logic, memory request generation and buffer write enable.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    issue_d    = issue_q;
    ret_d      = ret_q;
    out_d      = out_q;
    nop_fill_d = nop_fill_q;
    buf_we     = 1'b0;
    mem_rd     = 1'b0;
    case (state_q)
      IDLE: begin
        issue_d    = '0;
        ret_d      = '0;
        out_d      = '0;
        nop_fill_d = 1'b0;
        if (icache_ren) begin
          base_d  = {icache_addr[ADDR_W-1:IDX_W], {IDX_W{1'b0}}};
          state_d = FETCH;
        end
      end
      FETCH: begin
        mem_rd = (issue_q != FULL_CNT);
        if (mem_rd && !mem_busy) issue_d = issue_q + 1'b1;
        // Returns beyond a full line are stray and dropped.
        if (mem_rvalid && ret_q != FULL_CNT) begin
          buf_we = 1'b1;
          ret_d  = ret_q + 1'b1;
        end
        if (ret_q == FULL_CNT) state_d = STREAM;
        if (timeout_hit) begin
          state_d    = STREAM;
          issue_d    = '0;
          ret_d      = '0;
          nop_fill_d = 1'b1;
        end
      end
      STREAM: begin
        out_d = out_q + 1'b1;
        if (out_q == FULL_CNT - 1'b1) state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  icache_line_server_line_buffer #(
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buffer (
    .clk       (sdram_clk),
    .wr_en_i   (buf_we),
    .wr_idx_i  (ret_q[IDX_W-1:0]),
    .wr_data_i (mem_rdata),
    .rd_idx_i  (out_q[IDX_W-1:0]),
    .rd_data_o (buf_rd_data)
  );

  // Word address wraps naturally at ADDR_W bits.
  assign mem_addr  = mem_rd ? (base_q + ADDR_W'(issue_q)) : '0;
  assign line_ack  = (state_q == STREAM);
  assign line_data = (line_ack && !nop_fill_q) ? buf_rd_data : NOP_INSN;

endmodule

// File: tb/tb_icache_line_server.sv
// Testbench for icache_line_server: table of line requests with hand-computed
// base addresses and first-ack cycles, plus sequences for reset mid-fetch,
// ren held through the stream and (with ICACHE_RESP_TIMEOUT_EN) the watchdog.
`timescale 1ns/1ps
module tb_icache_line_server;
  import icache_line_server_pkg::*;

  localparam int AW = 21;
  localparam int LW = 16;

  logic          sdram_clk   = 1'b0;
  logic          reset_n     = 1'b0;
  logic          icache_ren  = 1'b0;
  logic [AW-1:0] icache_addr = '0;
  logic [31:0]   line_data;
  logic          line_ack;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_busy    = 1'b0;
  logic          mem_rvalid  = 1'b0;
  logic [31:0]   mem_rdata   = '0;

  always #5 sdram_clk = ~sdram_clk;

  icache_line_server #(
    .LINE_WORDS  (LW),
    .ADDR_W      (AW),
    .TIMEOUT_CYC (255)
  ) dut (
    .sdram_clk   (sdram_clk),
    .reset_n     (reset_n),
    .icache_ren  (icache_ren),
    .icache_addr (icache_addr),
    .line_data   (line_data),
    .line_ack    (line_ack),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_busy    (mem_busy),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  typedef struct {
    logic [AW-1:0] addr;
    bit            toggle;
    bit            early_drop;
    logic [AW-1:0] base;
    int            first;
  } vec_t;

  vec_t          vecs [6];
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc, first_ack, last_ack, rv_cnt, nop_err;
  bit            gap_seen, hold_ren, busy_toggle, early_drop, no_resp;
  logic [AW-1:0] issued_q [$];
  logic [31:0]   stream_q [$];

  // Memory contents: a recognisable tag plus the word address.
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {11'h3A5, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    issued_q.delete();
    stream_q.delete();
    first_ack = -1;
    last_ack  = -1;
    gap_seen  = 1'b0;
    nop_err   = 0;
    rv_cnt    = 0;
    cyc       = 0;
  endtask

  // One clock: sample outputs at the falling edge, then drive the zero-wait
  // memory response and next-cycle inputs just after the rising edge.
  task automatic cycle();
    logic          acc;
    logic [AW-1:0] acc_addr;
    @(negedge sdram_clk);
    acc      = mem_rd && !mem_busy;
    acc_addr = mem_addr;
    if (acc) issued_q.push_back(mem_addr);
    if (line_ack) begin
      stream_q.push_back(line_data);
      if (first_ack < 0) first_ack = cyc;
      last_ack = cyc;
    end else begin
      if (line_data !== NOP_INSN) nop_err++;
      if (first_ack >= 0) gap_seen = 1'b1;
    end
    @(posedge sdram_clk);
    #1;
    cyc++;
    mem_rvalid = acc && !no_resp;
    mem_rdata  = mem_rvalid ? mem_word(acc_addr) : 32'hDEAD_BEEF;
    if (mem_rvalid) rv_cnt++;
    mem_busy = busy_toggle && (cyc % 2 == 1);
    if (early_drop && cyc >= 2) icache_ren = 1'b0;
    if (first_ack >= 0 && !hold_ren) icache_ren = 1'b0;
  endtask

  task automatic start_req(input logic [AW-1:0] a);
    clear_logs();
    icache_ren  = 1'b1;
    icache_addr = a;
    mem_busy    = 1'b0;
  endtask

  task automatic wait_gap(input string name, input int budget);
    int n = 0;
    while (!gap_seen && n < budget) begin
      cycle();
      n++;
    end
    chk({name, "_gap_reached"}, 32'(gap_seen), 32'd1);
  endtask

  task automatic check_line(input string name, input logic [AW-1:0] base, input int first);
    int            bad_addr = 0;
    int            bad_data = 0;
    logic [AW-1:0] e;
    for (int i = 0; i < LW; i++) begin
      e = base + AW'(i);
      if (i < issued_q.size() && issued_q[i] !== e) bad_addr++;
      if (i < stream_q.size() && stream_q[i] !== mem_word(e)) bad_data++;
    end
    chk({name, "_first_ack"}, first_ack, first);
    chk({name, "_ack_count"}, 32'(stream_q.size()), LW);
    chk({name, "_ack_contig"}, last_ack - first_ack, LW - 1);
    chk({name, "_issue_count"}, 32'(issued_q.size()), LW);
    chk({name, "_addr_errs"}, bad_addr, 0);
    chk({name, "_data_errs"}, bad_data, 0);
    chk({name, "_nop_when_idle"}, nop_err, 0);
    $display("line %s base=%h first_ack=%0d acks=%0d issued=%0d", name, base, first_ack,
             stream_q.size(), issued_q.size());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    hold_ren = 0; busy_toggle = 0; early_drop = 0; no_resp = 0;
    clear_logs();

    vecs[0] = '{addr: 21'h000123, toggle: 0, early_drop: 0, base: 21'h000120, first: 19};
    vecs[1] = '{addr: 21'h000123, toggle: 1, early_drop: 0, base: 21'h000120, first: 35};
    vecs[2] = '{addr: 21'h1FFFF5, toggle: 0, early_drop: 0, base: 21'h1FFFF0, first: 19};
    vecs[3] = '{addr: 21'h000040, toggle: 0, early_drop: 1, base: 21'h000040, first: 19};
    vecs[4] = '{addr: 21'h1FFFF0, toggle: 1, early_drop: 0, base: 21'h1FFFF0, first: 35};
    vecs[5] = '{addr: 21'h0ABCDE, toggle: 0, early_drop: 0, base: 21'h0ABCD0, first: 19};

    // Reset state, checked with the clock running but reset held.
    #2;
    chk("rst_line_ack", 32'(line_ack), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_line_data", line_data, NOP_INSN);
    repeat (3) @(posedge sdram_clk);
    @(negedge sdram_clk);
    reset_n = 1'b1;
    @(posedge sdram_clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      busy_toggle = vecs[v].toggle;
      early_drop  = vecs[v].early_drop;
      start_req(vecs[v].addr);
      wait_gap($sformatf("v%0d", v), 200);
      check_line($sformatf("v%0d", v), vecs[v].base, vecs[v].first);
    end
    busy_toggle = 0;
    early_drop  = 0;

    // Reset pulsed at the 8th return: outputs clear without a clock edge.
    start_req(21'h000200);
    for (int n = 0; n < 100 && rv_cnt < 8; n++) cycle();
    chk("rstmid_returns", rv_cnt, 8);
    chk("rstmid_pre_mem_rd", 32'(mem_rd), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rstmid_mem_rd", 32'(mem_rd), 32'd0);
    chk("rstmid_mem_addr", 32'(mem_addr), 32'd0);
    chk("rstmid_line_ack", 32'(line_ack), 32'd0);
    chk("rstmid_line_data", line_data, NOP_INSN);
    $display("reset mid-fetch after %0d returns", rv_cnt);
    icache_ren = 1'b0;
    @(negedge sdram_clk);
    reset_n = 1'b1;
    @(posedge sdram_clk);
    #1;
    // mem_rvalid from before reset is still high here, seen by an idle DUT.
    start_req(21'h000040);
    wait_gap("after_rst", 200);
    check_line("after_rst", 21'h000040, 19);

    // ren held through stream and gap: one gap cycle, one idle cycle, refetch.
    hold_ren = 1'b1;
    start_req(21'h000300);
    wait_gap("hold", 200);
    check_line("hold", 21'h000300, 19);
    chk("hold_single_gap", 32'(gap_seen), 32'd1);
    clear_logs();
    cycle();
    chk("hold_idle_no_rd", 32'(issued_q.size()), 32'd0);
    chk("hold_idle_no_ack", 32'(stream_q.size()), 32'd0);
    cycle();
    chk("hold_refetch_issued", 32'(issued_q.size()), 32'd1);
    chk("hold_refetch_addr", 32'(issued_q.size() > 0 ? issued_q[0] : '1), 32'h300);
    hold_ren = 1'b0;
    wait_gap("hold2", 200);
    check_line("hold2", 21'h000300, 19);

`ifdef ICACHE_RESP_TIMEOUT_EN
    begin
      int bad_nop = 0;
      no_resp = 1'b1;
      start_req(21'h000500);
      wait_gap("wdog", 400);
      for (int i = 0; i < stream_q.size(); i++) if (stream_q[i] !== NOP_INSN) bad_nop++;
      chk("wdog_first_ack", first_ack, 256);
      chk("wdog_ack_count", 32'(stream_q.size()), LW);
      chk("wdog_nop_words", bad_nop, 0);
      $display("line wdog first_ack=%0d acks=%0d", first_ack, stream_q.size());
      no_resp = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
